// File: rtl/minesweeper_core.sv
// Minesweeper game engine for a ROWS x COLS board: bomb latch, neighbour counts, cursor,
// flags, reveal with flood-fill of zero regions, and win/lose detection.
module minesweeper_core #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned XW   = $clog2(COLS),
  parameter int unsigned YW   = $clog2(ROWS),
  parameter int unsigned NW   = $clog2(ROWS * COLS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] bomb_map,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_flag,
  input  logic                 btn_select,
  input  logic [XW-1:0]        rd_x,
  input  logic [YW-1:0]        rd_y,
  output logic [3:0]           rd_code,
  output logic [XW-1:0]        cursor_x,
  output logic [YW-1:0]        cursor_y,
  output logic                 wr_enable,
  output logic [XW-1:0]        wr_x,
  output logic [YW-1:0]        wr_y,
  output logic [NW-1:0]        flags_left,
  output logic                 busy,
  output logic                 won,
  output logic                 lost
);
  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = $clog2(N);

  typedef enum logic [2:0] {StIdle, StInit, StPlay, StFill, StWin, StLose} state_e;

  state_e          state_q;
  logic [N-1:0]    bombs_q;
  logic [3:0]      cell_q [N];
  logic [3:0]      cnt_q  [N];
  logic [XW-1:0]   sx_q;
  logic [YW-1:0]   sy_q;
  logic [NW-1:0]   bomb_total_q, revealed_q;
  logic            changed_q;

  logic [NW-1:0]   popcnt, safe_total;
  logic [AW-1:0]   scan_idx, cur_idx, rd_idx, ni;
  logic [3:0]      nbr_cnt, cur_cell;
  logic            nbr_zero, scan_last, rd_ok, reveal_now;
  int              nx, ny;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < int'(N); i++) popcnt = popcnt + NW'(bomb_map[i]);
  end

  assign safe_total = NW'(N) - bomb_total_q;
  assign scan_idx   = AW'(32'(sy_q) * COLS + 32'(sx_q));
  assign cur_idx    = AW'(32'(cursor_y) * COLS + 32'(cursor_x));
  assign rd_idx     = AW'(32'(rd_y) * COLS + 32'(rd_x));
  assign rd_ok      = (32'(rd_x) < COLS) && (32'(rd_y) < ROWS);
  assign cur_cell   = cell_q[cur_idx];
  assign scan_last  = (32'(sx_q) == COLS - 1) && (32'(sy_q) == ROWS - 1);
  assign busy       = (state_q == StInit) || (state_q == StFill);

  // Bomb count and "touches a revealed zero" for the cell under the scan pointer.
  always_comb begin
    nbr_cnt  = '0;
    nbr_zero = 1'b0;
    nx       = 0;
    ny       = 0;
    ni       = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(sx_q) + dx;
        ny = int'(sy_q) + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < int'(COLS) && ny >= 0 && ny < int'(ROWS))
        begin
          ni      = AW'(ny * int'(COLS) + nx);
          nbr_cnt = nbr_cnt + 4'(bombs_q[ni]);
          if (cell_q[ni] == 4'd0) nbr_zero = 1'b1;
        end
      end
    end
  end

  assign reveal_now = (state_q == StFill) && (cell_q[scan_idx] == 4'd9) && nbr_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      bombs_q      <= '0;
      for (int i = 0; i < int'(N); i++) begin
        cell_q[i] <= 4'd9;
        cnt_q[i]  <= 4'd0;
      end
      sx_q         <= '0;
      sy_q         <= '0;
      bomb_total_q <= '0;
      revealed_q   <= '0;
      changed_q    <= 1'b0;
      rd_code      <= 4'd9;
      cursor_x     <= '0;
      cursor_y     <= '0;
      wr_enable    <= 1'b0;
      wr_x         <= '0;
      wr_y         <= '0;
      flags_left   <= '0;
      won          <= 1'b0;
      lost         <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      rd_code   <= rd_ok ? cell_q[rd_idx] : 4'd9;
      if (start) begin
        state_q      <= StInit;
        bombs_q      <= bomb_map;
        bomb_total_q <= popcnt;
        flags_left   <= popcnt;
        revealed_q   <= '0;
        for (int i = 0; i < int'(N); i++) cell_q[i] <= 4'd9;
        won          <= 1'b0;
        lost         <= 1'b0;
        cursor_x     <= '0;
        cursor_y     <= '0;
        sx_q         <= '0;
        sy_q         <= '0;
      end else begin
        // Shared raster scan pointer for INIT and FILL.
        if (state_q == StInit || state_q == StFill) begin
          if (32'(sx_q) == COLS - 1) begin
            sx_q <= '0;
            sy_q <= (32'(sy_q) == ROWS - 1) ? '0 : sy_q + 1'b1;
          end else begin
            sx_q <= sx_q + 1'b1;
          end
        end
        case (state_q)
          StInit: begin
            cnt_q[scan_idx] <= nbr_cnt;
            if (scan_last) begin
              if (bomb_total_q == NW'(N)) begin
                won     <= 1'b1;
                state_q <= StWin;
              end else begin
                state_q <= StPlay;
              end
            end
          end
          StPlay: begin
            if (btn_select) begin
              if (cur_cell == 4'd9) begin
                wr_enable <= 1'b1;
                wr_x      <= cursor_x;
                wr_y      <= cursor_y;
                if (bombs_q[cur_idx]) begin
                  cell_q[cur_idx] <= 4'd11;
                  lost            <= 1'b1;
                  state_q         <= StLose;
                end else begin
                  cell_q[cur_idx] <= cnt_q[cur_idx];
                  revealed_q      <= revealed_q + 1'b1;
                  if (cnt_q[cur_idx] == 4'd0) begin
                    state_q   <= StFill;
                    sx_q      <= '0;
                    sy_q      <= '0;
                    changed_q <= 1'b0;
                  end else if (revealed_q + 1'b1 == safe_total) begin
                    won     <= 1'b1;
                    state_q <= StWin;
                  end
                end
              end
            end else if (btn_flag) begin
              if (cur_cell == 4'd9 && flags_left != '0) begin
                cell_q[cur_idx] <= 4'd10;
                flags_left      <= flags_left - 1'b1;
                wr_enable       <= 1'b1;
                wr_x            <= cursor_x;
                wr_y            <= cursor_y;
              end else if (cur_cell == 4'd10) begin
                cell_q[cur_idx] <= 4'd9;
                flags_left      <= flags_left + 1'b1;
                wr_enable       <= 1'b1;
                wr_x            <= cursor_x;
                wr_y            <= cursor_y;
              end
            end else begin
              if (btn_right && !btn_left)
                cursor_x <= (32'(cursor_x) == COLS - 1) ? '0 : cursor_x + 1'b1;
              else if (btn_left && !btn_right)
                cursor_x <= (cursor_x == '0) ? XW'(COLS - 1) : cursor_x - 1'b1;
              if (btn_down && !btn_up)
                cursor_y <= (32'(cursor_y) == ROWS - 1) ? '0 : cursor_y + 1'b1;
              else if (btn_up && !btn_down)
                cursor_y <= (cursor_y == '0) ? YW'(ROWS - 1) : cursor_y - 1'b1;
            end
          end
          StFill: begin
            if (reveal_now) begin
              cell_q[scan_idx] <= cnt_q[scan_idx];
              revealed_q       <= revealed_q + 1'b1;
              wr_enable        <= 1'b1;
              wr_x             <= sx_q;
              wr_y             <= sy_q;
            end
            if (!scan_last) begin
              changed_q <= changed_q | reveal_now;
            end else if (changed_q || reveal_now) begin
              changed_q <= 1'b0;
            end else if (revealed_q == safe_total) begin
              won     <= 1'b1;
              state_q <= StWin;
            end else begin
              state_q <= StPlay;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_minesweeper_core.sv
// Directed bench for minesweeper_core on the default 8x8 board.
module tb_minesweeper_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] bomb_map;
  logic        btn_up, btn_down, btn_left, btn_right, btn_flag, btn_select;
  logic [2:0]  rd_x, rd_y;
  logic [3:0]  rd_code;
  logic [2:0]  cursor_x, cursor_y, wr_x, wr_y;
  logic        wr_enable, busy, won, lost;
  logic [6:0]  flags_left;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int cycles;
  int base;
  logic [3:0] c;

  minesweeper_core dut (
    .clk(clk), .reset(reset), .start(start), .bomb_map(bomb_map),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_flag(btn_flag), .btn_select(btn_select), .rd_x(rd_x), .rd_y(rd_y),
    .rd_code(rd_code), .cursor_x(cursor_x), .cursor_y(cursor_y), .wr_enable(wr_enable),
    .wr_x(wr_x), .wr_y(wr_y), .flags_left(flags_left), .busy(busy), .won(won), .lost(lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (wr_enable === 1'b1) wr_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_flag = 0; btn_select = 0;
  endtask

  task automatic read_cell(input int x, input int y, output logic [3:0] code);
    rd_x = 3'(x);
    rd_y = 3'(y);
    @(negedge clk);
    code = rd_code;
  endtask

  task automatic wait_idle();
    cycles = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic new_game(input logic [63:0] map);
    bomb_map = map; start = 1; tick();
    wait_idle();
  endtask

  initial begin
    reset = 0; start = 0; bomb_map = '0; rd_x = 0; rd_y = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_flag = 0; btn_select = 0;
    repeat (3) @(negedge clk);
    check("rst_rd_code", 32'(rd_code), 9);
    check("rst_cursor", {cursor_x, cursor_y}, 0);
    check("rst_flags", 32'(flags_left), 0);
    check("rst_flags_out", {busy, won, lost, wr_enable}, 0);
    check("rst_wr_xy", {wr_x, wr_y}, 0);
    reset = 1;
    @(negedge clk);

    // Single bomb at (0,0): INIT must take exactly 64 busy cycles.
    bomb_map = 64'h1; start = 1; tick();
    wait_idle();
    check("init_cycles", cycles, 64);
    check("init_cursor", {cursor_x, cursor_y}, 0);
    check("init_flags", 32'(flags_left), 1);
    read_cell(1, 1, c);
    check("init_rd11", 32'(c), 9);

    // Cursor wrap and simultaneous opposite buttons.
    btn_left = 1; tick();
    check("wrap_left", 32'(cursor_x), 7);
    btn_up = 1; tick();
    check("wrap_up", 32'(cursor_y), 7);
    btn_up = 1; btn_down = 1; btn_right = 1; tick();
    check("updown_right", {cursor_x, cursor_y}, {3'd0, 3'd7});
    repeat (5) begin btn_right = 1; tick(); end
    repeat (2) begin btn_up = 1; tick(); end
    check("at_55", {cursor_x, cursor_y}, {3'd5, 3'd5});
    btn_left = 1; btn_right = 1; tick();
    check("leftright", 32'(cursor_x), 5);

    // Flag budget with one bomb.
    btn_flag = 1; tick();
    check("flag_wr_en", 32'(wr_enable), 1);
    check("flag_wr_xy", {wr_x, wr_y}, {3'd5, 3'd5});
    check("flag_left0", 32'(flags_left), 0);
    tick();
    check("wr_en_one_cycle", 32'(wr_enable), 0);
    read_cell(5, 5, c);
    check("flag_code", 32'(c), 10);
    btn_right = 1; tick();
    btn_down = 1; tick();
    base = wr_cnt;
    btn_flag = 1; tick();
    tick();
    check("flag_budget_wr", wr_cnt - base, 0);
    check("flag_budget_left", 32'(flags_left), 0);
    read_cell(6, 6, c);
    check("flag_budget_code", 32'(c), 9);
    btn_left = 1; tick();
    btn_up = 1; tick();
    btn_flag = 1; tick();
    check("unflag_left", 32'(flags_left), 1);
    read_cell(5, 5, c);
    check("unflag_code", 32'(c), 9);
    btn_flag = 1; tick();
    base = wr_cnt;
    btn_select = 1; tick();
    tick();
    check("sel_flag_wr", wr_cnt - base, 0);
    check("sel_flag_lost", 32'(lost), 0);
    read_cell(5, 5, c);
    check("sel_flag_code", 32'(c), 10);

    // Lose on the bomb at (0,0).
    new_game(64'h1);
    btn_select = 1; tick();
    check("lose_lost", 32'(lost), 1);
    check("lose_wr", {wr_enable, wr_x, wr_y}, {1'b1, 3'd0, 3'd0});
    read_cell(0, 0, c);
    check("lose_code", 32'(c), 11);
    btn_right = 1; tick();
    check("lose_no_move", 32'(cursor_x), 0);
    check("lose_won", {won, lost}, {1'b0, 1'b1});

    // Flood fill to a win with only (7,7) mined.
    new_game(64'h8000_0000_0000_0000);
    base = wr_cnt;
    btn_select = 1; tick();
    check("fill_busy", 32'(busy), 1);
    wait_idle();
    check("fill_done", 32'(busy), 0);
    check("fill_wr_pulses", wr_cnt - base, 63);
    check("fill_won", {won, lost}, {1'b1, 1'b0});
    read_cell(6, 6, c);
    check("fill_rd66", 32'(c), 1);
    read_cell(7, 7, c);
    check("fill_rd77", 32'(c), 9);
    read_cell(0, 0, c);
    check("fill_rd00", 32'(c), 0);
    read_cell(7, 6, c);
    check("fill_rd76", 32'(c), 1);

    // Restart in the middle of a fill.
    new_game(64'h8000_0000_0000_0000);
    btn_select = 1; tick();
    repeat (10) tick();
    check("midfill_busy", 32'(busy), 1);
    bomb_map = 64'h1; start = 1; tick();
    check("restart_state", {busy, won, lost}, {1'b1, 1'b0, 1'b0});
    wait_idle();
    check("restart_init_cycles", cycles, 64);
    check("restart_flags", 32'(flags_left), 1);
    read_cell(1, 0, c);
    check("restart_rd10", 32'(c), 9);
    read_cell(3, 3, c);
    check("restart_rd33", 32'(c), 9);
    btn_select = 1; tick();
    check("restart_new_map", 32'(lost), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
